// File: rtl/yonga_can_depacketizer_if.sv
// Bundle of the depacketizer control, bus-bit and published-message signals.
// The master drives the sample stream; the slave (the parser) returns the message fields.
interface yonga_can_depacketizer_if;
  logic        i_depacketizer_en;
  logic        i_sample_pulse;
  logic        i_message_bit;
  logic        o_depacketizer_busy;
  logic        o_ack_slot;
  logic [10:0] o_depacketizer_message_sid;
  logic        o_depacketizer_message_ide;
  logic [17:0] o_depacketizer_message_eid;
  logic        o_depacketizer_message_rtr;
  logic [3:0]  o_depacketizer_message_dlc;
  logic [63:0] o_depacketizer_message_data;
  logic        o_depacketizer_valid;
  logic        o_depacketizer_err;
  logic [2:0]  o_depacketizer_err_code;

  modport master (
    output i_depacketizer_en, i_sample_pulse, i_message_bit,
    input  o_depacketizer_busy, o_ack_slot,
           o_depacketizer_message_sid, o_depacketizer_message_ide,
           o_depacketizer_message_eid, o_depacketizer_message_rtr,
           o_depacketizer_message_dlc, o_depacketizer_message_data,
           o_depacketizer_valid, o_depacketizer_err, o_depacketizer_err_code
  );

  modport slave (
    input  i_depacketizer_en, i_sample_pulse, i_message_bit,
    output o_depacketizer_busy, o_ack_slot,
           o_depacketizer_message_sid, o_depacketizer_message_ide,
           o_depacketizer_message_eid, o_depacketizer_message_rtr,
           o_depacketizer_message_dlc, o_depacketizer_message_data,
           o_depacketizer_valid, o_depacketizer_err, o_depacketizer_err_code
  );
endinterface

// File: rtl/yonga_can_depacketizer.sv
// CAN 2.0A/B receive parser: destuffs sampled bus bits, parses fields, checks CRC-15 and form,
// requests the ACK slot and publishes good frames with a one-cycle valid pulse.
module yonga_can_depacketizer #(
  parameter int unsigned IDLE_BITS = 11,
  parameter int unsigned IFS_BITS  = 3
) (
  input  logic                     i_depacketizer_clk,
  input  logic                     i_depacketizer_rst,
  yonga_can_depacketizer_if.slave  bus
);

  localparam int unsigned MAX_BITS = (IDLE_BITS > IFS_BITS) ? IDLE_BITS : IFS_BITS;
  localparam int unsigned CW       = $clog2(MAX_BITS + 1);

  localparam logic [2:0] ERR_STUFF = 3'd1;
  localparam logic [2:0] ERR_FORM  = 3'd2;
  localparam logic [2:0] ERR_CRC   = 3'd3;

  typedef enum logic [3:0] {
    S_WAIT_IDLE, S_IDLE, S_ARB, S_EID, S_CTRL, S_DATA,
    S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF
  } state_t;

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    crc15_step = {crc[13:0], 1'b0} ^ ((b ^ crc[14]) ? 15'h4599 : 15'h0000);
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          need_ifs_q, need_ifs_d;
  logic [6:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    run_q, run_d;
  logic          last_q, last_d;
  logic [14:0]   crc_q, crc_d;
  logic [14:0]   crc_rx_q, crc_rx_d;
  logic [3:0]    nbytes_q, nbytes_d;
  logic [10:0]   sid_s_q, sid_s_d;
  logic          ide_s_q, ide_s_d;
  logic [17:0]   eid_s_q, eid_s_d;
  logic          rtr_s_q, rtr_s_d;
  logic [3:0]    dlc_s_q, dlc_s_d;
  logic [63:0]   data_s_q, data_s_d;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;
  logic [10:0]   sid_q, sid_d;
  logic          ide_q, ide_d;
  logic [17:0]   eid_q, eid_d;
  logic          rtr_q, rtr_d;
  logic [3:0]    dlc_q, dlc_d;
  logic [63:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [2:0]    err_code_q, err_code_d;

  logic          smp;
  logic          in_bit;
  logic          destuff_region;
  logic          stuff_bit;
  logic          fail;
  logic [2:0]    fail_code;
  logic [CW-1:0] idle_last;
  logic [14:0]   crc_upd;
  logic [3:0]    dlc_new;
  logic [3:0]    nbytes_new;
  logic [5:0]    data_idx;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    need_ifs_d = need_ifs_q;
    bit_cnt_d  = bit_cnt_q;
    run_d      = run_q;
    last_d     = last_q;
    crc_d      = crc_q;
    crc_rx_d   = crc_rx_q;
    nbytes_d   = nbytes_q;
    sid_s_d    = sid_s_q;
    ide_s_d    = ide_s_q;
    eid_s_d    = eid_s_q;
    rtr_s_d    = rtr_s_q;
    dlc_s_d    = dlc_s_q;
    data_s_d   = data_s_q;
    busy_d     = busy_q;
    ack_d      = ack_q;
    sid_d      = sid_q;
    ide_d      = ide_q;
    eid_d      = eid_q;
    rtr_d      = rtr_q;
    dlc_d      = dlc_q;
    data_d     = data_q;
    err_code_d = err_code_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    fail       = 1'b0;
    fail_code  = '0;
    stuff_bit  = 1'b0;
    smp        = bus.i_depacketizer_en && bus.i_sample_pulse;
    in_bit     = bus.i_message_bit;
    idle_last  = need_ifs_q ? CW'(IFS_BITS - 1) : CW'(IDLE_BITS - 1);
    crc_upd    = crc15_step(crc_q, in_bit);
    dlc_new    = {dlc_s_q[2:0], in_bit};
    nbytes_new = rtr_s_q ? 4'd0 : ((dlc_new > 4'd8) ? 4'd8 : dlc_new);
    data_idx   = {bit_cnt_q[5:3], ~bit_cnt_q[2:0]};
    destuff_region = state_q inside {S_ARB, S_EID, S_CTRL, S_DATA, S_CRC};

    if (!bus.i_depacketizer_en) begin
      state_d    = S_WAIT_IDLE;
      idle_cnt_d = '0;
      need_ifs_d = 1'b0;
      busy_d     = 1'b0;
      ack_d      = 1'b0;
    end else if (smp) begin
      // A run of five ending on the last CRC bit still owes a stuff bit before the delimiter.
      if ((destuff_region || state_q == S_CRC_DEL) && run_q == 3'd5) begin
        stuff_bit = 1'b1;
        if (in_bit == last_q) begin
          fail      = 1'b1;
          fail_code = ERR_STUFF;
        end else begin
          last_d = in_bit;
          run_d  = 3'd1;
        end
      end else if (destuff_region) begin
        run_d  = (in_bit == last_q) ? run_q + 3'd1 : 3'd1;
        last_d = in_bit;
      end

      if (!stuff_bit) begin
        unique case (state_q)
          S_WAIT_IDLE: begin
            if (!in_bit) begin
              idle_cnt_d = '0;
            end else if (idle_cnt_q == idle_last) begin
              idle_cnt_d = '0;
              state_d    = S_IDLE;
            end else begin
              idle_cnt_d = idle_cnt_q + 1'b1;
            end
          end
          S_IDLE: begin
            if (!in_bit) begin
              state_d   = S_ARB;
              busy_d    = 1'b1;
              bit_cnt_d = '0;
              run_d     = 3'd1;
              last_d    = 1'b0;
              crc_d     = crc15_step(15'h0000, 1'b0);
              crc_rx_d  = '0;
              nbytes_d  = '0;
              sid_s_d   = '0;
              ide_s_d   = 1'b0;
              eid_s_d   = '0;
              rtr_s_d   = 1'b0;
              dlc_s_d   = '0;
              data_s_d  = '0;
            end
          end
          S_ARB: begin
            crc_d     = crc_upd;
            bit_cnt_d = bit_cnt_q + 7'd1;
            if (bit_cnt_q < 7'd11) sid_s_d = {sid_s_q[9:0], in_bit};
            if (bit_cnt_q == 7'd11) rtr_s_d = in_bit;
            if (bit_cnt_q == 7'd12) begin
              ide_s_d   = in_bit;
              bit_cnt_d = '0;
              state_d   = in_bit ? S_EID : S_CTRL;
            end
          end
          S_EID: begin
            crc_d     = crc_upd;
            bit_cnt_d = bit_cnt_q + 7'd1;
            if (bit_cnt_q < 7'd18) eid_s_d = {eid_s_q[16:0], in_bit};
            if (bit_cnt_q == 7'd18) rtr_s_d = in_bit;
            if (bit_cnt_q == 7'd19) begin
              bit_cnt_d = '0;
              state_d   = S_CTRL;
            end
          end
          S_CTRL: begin
            crc_d     = crc_upd;
            bit_cnt_d = bit_cnt_q + 7'd1;
            if (bit_cnt_q != 7'd0) dlc_s_d = dlc_new;
            if (bit_cnt_q == 7'd4) begin
              nbytes_d  = nbytes_new;
              bit_cnt_d = '0;
              state_d   = (nbytes_new == 4'd0) ? S_CRC : S_DATA;
            end
          end
          S_DATA: begin
            crc_d              = crc_upd;
            data_s_d[data_idx] = in_bit;
            bit_cnt_d          = bit_cnt_q + 7'd1;
            if ((bit_cnt_q + 7'd1) == {nbytes_q, 3'b000}) begin
              bit_cnt_d = '0;
              state_d   = S_CRC;
            end
          end
          S_CRC: begin
            crc_rx_d  = {crc_rx_q[13:0], in_bit};
            bit_cnt_d = bit_cnt_q + 7'd1;
            if (bit_cnt_q == 7'd14) begin
              bit_cnt_d = '0;
              state_d   = S_CRC_DEL;
            end
          end
          S_CRC_DEL: begin
            if (!in_bit) begin
              fail      = 1'b1;
              fail_code = ERR_FORM;
            end else if (crc_rx_q != crc_q) begin
              fail      = 1'b1;
              fail_code = ERR_CRC;
            end else begin
              state_d = S_ACK;
              ack_d   = 1'b1;
            end
          end
          S_ACK: begin
            state_d = S_ACK_DEL;
            ack_d   = 1'b0;
          end
          S_ACK_DEL: begin
            if (!in_bit) begin
              fail      = 1'b1;
              fail_code = ERR_FORM;
            end else begin
              state_d   = S_EOF;
              bit_cnt_d = '0;
            end
          end
          S_EOF: begin
            if (!in_bit) begin
              fail      = 1'b1;
              fail_code = ERR_FORM;
            end else if (bit_cnt_q == 7'd6) begin
              sid_d      = sid_s_q;
              ide_d      = ide_s_q;
              eid_d      = eid_s_q;
              rtr_d      = rtr_s_q;
              dlc_d      = dlc_s_q;
              data_d     = data_s_q;
              valid_d    = 1'b1;
              busy_d     = 1'b0;
              state_d    = S_WAIT_IDLE;
              need_ifs_d = 1'b1;
              idle_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 7'd1;
            end
          end
          default: state_d = S_WAIT_IDLE;
        endcase
      end

      if (fail) begin
        state_d    = S_WAIT_IDLE;
        need_ifs_d = 1'b0;
        idle_cnt_d = '0;
        busy_d     = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b1;
        err_code_d = fail_code;
      end
    end
  end

  always_ff @(posedge i_depacketizer_clk) begin
    if (i_depacketizer_rst) begin
      state_q    <= S_WAIT_IDLE;
      idle_cnt_q <= '0;
      need_ifs_q <= 1'b0;
      bit_cnt_q  <= '0;
      run_q      <= '0;
      last_q     <= 1'b0;
      crc_q      <= '0;
      crc_rx_q   <= '0;
      nbytes_q   <= '0;
      sid_s_q    <= '0;
      ide_s_q    <= 1'b0;
      eid_s_q    <= '0;
      rtr_s_q    <= 1'b0;
      dlc_s_q    <= '0;
      data_s_q   <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      sid_q      <= '0;
      ide_q      <= 1'b0;
      eid_q      <= '0;
      rtr_q      <= 1'b0;
      dlc_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      need_ifs_q <= need_ifs_d;
      bit_cnt_q  <= bit_cnt_d;
      run_q      <= run_d;
      last_q     <= last_d;
      crc_q      <= crc_d;
      crc_rx_q   <= crc_rx_d;
      nbytes_q   <= nbytes_d;
      sid_s_q    <= sid_s_d;
      ide_s_q    <= ide_s_d;
      eid_s_q    <= eid_s_d;
      rtr_s_q    <= rtr_s_d;
      dlc_s_q    <= dlc_s_d;
      data_s_q   <= data_s_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      sid_q      <= sid_d;
      ide_q      <= ide_d;
      eid_q      <= eid_d;
      rtr_q      <= rtr_d;
      dlc_q      <= dlc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.o_depacketizer_busy         = busy_q;
  assign bus.o_ack_slot                  = ack_q;
  assign bus.o_depacketizer_message_sid  = sid_q;
  assign bus.o_depacketizer_message_ide  = ide_q;
  assign bus.o_depacketizer_message_eid  = eid_q;
  assign bus.o_depacketizer_message_rtr  = rtr_q;
  assign bus.o_depacketizer_message_dlc  = dlc_q;
  assign bus.o_depacketizer_message_data = data_q;
  assign bus.o_depacketizer_valid        = valid_q;
  assign bus.o_depacketizer_err          = err_q;
  assign bus.o_depacketizer_err_code     = err_code_q;

endmodule

// File: tb/tb_yonga_can_depacketizer.sv
// Bench for yonga_can_depacketizer: frames are assembled bit-by-bit from message fields
// (CRC, stuffing, delimiters) and the published fields/pulses compared to the message.
module tb_yonga_can_depacketizer;

  typedef struct packed {
    logic        ide;
    logic        rtr;
    logic [10:0] sid;
    logic [17:0] eid;
    logic [3:0]  dlc;
    logic [63:0] data;
  } msg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  yonga_can_depacketizer_if bus ();

  yonga_can_depacketizer #(.IDLE_BITS(11), .IFS_BITS(3)) dut (
    .i_depacketizer_clk (clk),
    .i_depacketizer_rst (rst),
    .bus                (bus)
  );

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int ack_cyc = 0;
  int both_cnt = 0;

  bit frame_q[$];

  logic [10:0] exp_sid;
  logic        exp_ide;
  logic [17:0] exp_eid;
  logic        exp_rtr;
  logic [3:0]  exp_dlc;
  logic [63:0] exp_data;

  always @(negedge clk) begin
    if (bus.o_depacketizer_valid) valid_cnt <= valid_cnt + 1;
    if (bus.o_depacketizer_err)   err_cnt   <= err_cnt + 1;
    if (bus.o_ack_slot)           ack_cyc   <= ack_cyc + 1;
    if (bus.o_depacketizer_valid && bus.o_depacketizer_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int nbytes_of(input msg_t m);
    if (m.rtr) return 0;
    return (m.dlc > 4'd8) ? 8 : int'(m.dlc);
  endfunction

  // Builds the wire-level bit sequence for m; flip >= 0 corrupts that data bit after CRC generation.
  task automatic build_frame(input msg_t m, input int flip, input bit ack_val);
    bit raw[$];
    bit [14:0] crc;
    int data_start;
    int run;
    bit prev;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(m.sid[i]);
    if (m.ide) begin
      raw.push_back(1'b1);
      raw.push_back(1'b1);
      for (int i = 17; i >= 0; i--) raw.push_back(m.eid[i]);
      raw.push_back(m.rtr);
      raw.push_back(1'b0);
    end else begin
      raw.push_back(m.rtr);
      raw.push_back(1'b0);
    end
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(m.dlc[i]);
    data_start = raw.size();
    for (int b = 0; b < nbytes_of(m); b++)
      for (int i = 7; i >= 0; i--) raw.push_back(m.data[8*b+i]);
    crc = '0;
    foreach (raw[k]) crc = {crc[13:0], 1'b0} ^ ((raw[k] ^ crc[14]) ? 15'h4599 : 15'h0000);
    if (flip >= 0) raw[data_start + flip] = ~raw[data_start + flip];
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    frame_q.delete();
    run = 0;
    prev = 1'b0;
    foreach (raw[k]) begin
      if (run == 5) begin
        frame_q.push_back(~prev);
        prev = ~prev;
        run = 1;
      end
      frame_q.push_back(raw[k]);
      if (run > 0 && raw[k] == prev) run++;
      else run = 1;
      prev = raw[k];
    end
    if (run == 5) frame_q.push_back(~prev);
    frame_q.push_back(1'b1);
    frame_q.push_back(ack_val);
    frame_q.push_back(1'b1);
    for (int i = 0; i < 7; i++) frame_q.push_back(1'b1);
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    bus.i_sample_pulse = 1'b1;
    bus.i_message_bit  = b;
    @(negedge clk);
    bus.i_sample_pulse = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input int n);
    int lim;
    lim = (n < 0 || n > frame_q.size()) ? frame_q.size() : n;
    for (int i = 0; i < lim; i++) send_bit(frame_q[i]);
  endtask

  task automatic check_fields(input string tag);
    check({tag, "_sid"},  64'(bus.o_depacketizer_message_sid),  64'(exp_sid));
    check({tag, "_ide"},  64'(bus.o_depacketizer_message_ide),  64'(exp_ide));
    check({tag, "_eid"},  64'(bus.o_depacketizer_message_eid),  64'(exp_eid));
    check({tag, "_rtr"},  64'(bus.o_depacketizer_message_rtr),  64'(exp_rtr));
    check({tag, "_dlc"},  64'(bus.o_depacketizer_message_dlc),  64'(exp_dlc));
    check({tag, "_data"}, bus.o_depacketizer_message_data,      exp_data);
  endtask

  task automatic good_frame(input string tag, input msg_t m);
    int v0, e0, a0;
    v0 = valid_cnt; e0 = err_cnt; a0 = ack_cyc;
    build_frame(m, -1, 1'($urandom_range(0, 1)));
    send_frame(-1);
    idle(3);
    exp_sid  = m.sid;
    exp_ide  = m.ide;
    exp_eid  = m.ide ? m.eid : 18'h0;
    exp_rtr  = m.rtr;
    exp_dlc  = m.dlc;
    exp_data = '0;
    for (int b = 0; b < nbytes_of(m); b++) exp_data[8*b +: 8] = m.data[8*b +: 8];
    check({tag, "_valid"}, 64'(valid_cnt - v0), 64'd1);
    check({tag, "_noerr"}, 64'(err_cnt - e0),   64'd0);
    check({tag, "_ack"},   64'(ack_cyc - a0),   64'd4);
    check_fields(tag);
  endtask

  task automatic crc_bad_frame(input string tag, input msg_t m);
    int v0, e0, a0;
    v0 = valid_cnt; e0 = err_cnt; a0 = ack_cyc;
    build_frame(m, $urandom_range(0, nbytes_of(m) * 8 - 1), 1'b0);
    send_frame(-1);
    idle(11);
    check({tag, "_err"},     64'(err_cnt - e0),   64'd1);
    check({tag, "_code"},    64'(bus.o_depacketizer_err_code), 64'd3);
    check({tag, "_novalid"}, 64'(valid_cnt - v0), 64'd0);
    check({tag, "_noack"},   64'(ack_cyc - a0),   64'd0);
    check_fields(tag);
  endtask

  function automatic msg_t rand_msg();
    msg_t m;
    m.ide  = 1'($urandom_range(0, 1));
    m.rtr  = ($urandom_range(0, 4) == 0);
    m.sid  = 11'($urandom);
    m.eid  = 18'($urandom);
    m.dlc  = 4'($urandom);
    m.data = {$urandom, $urandom};
    return m;
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    msg_t m;
    int v0, e0;
    bus.i_depacketizer_en = 1'b1;
    bus.i_sample_pulse    = 1'b0;
    bus.i_message_bit     = 1'b1;
    exp_sid = '0; exp_ide = 1'b0; exp_eid = '0; exp_rtr = 1'b0; exp_dlc = '0; exp_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  64'(bus.o_depacketizer_busy),     64'd0);
    check("rst_ack",   64'(bus.o_ack_slot),              64'd0);
    check("rst_valid", 64'(bus.o_depacketizer_valid),    64'd0);
    check("rst_err",   64'(bus.o_depacketizer_err),      64'd0);
    check("rst_code",  64'(bus.o_depacketizer_err_code), 64'd0);
    check_fields("rst");

    // 1: standard frame
    idle(11);
    m = '0; m.sid = 11'h123; m.dlc = 4'd2; m.data = 64'hCDAB;
    good_frame("std", m);
    check("std_data_lit", bus.o_depacketizer_message_data, 64'hCDAB);

    // 2: extended frame, heavy stuffing
    m = '0; m.ide = 1'b1; m.sid = 11'h7FF; m.eid = 18'h3FFFF; m.dlc = 4'd8; m.data = '1;
    good_frame("ext", m);

    // 3: stuff error inside SID, then IDLE_BITS boundary
    v0 = valid_cnt; e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    check("stuff_err",  64'(err_cnt - e0), 64'd1);
    check("stuff_code", 64'(bus.o_depacketizer_err_code), 64'd1);
    check("stuff_busy", 64'(bus.o_depacketizer_busy), 64'd0);
    idle(10);
    m = '0; m.sid = 11'h055; m.dlc = 4'd1; m.data = 64'h5A;
    build_frame(m, -1, 1'b0);
    send_frame(-1);
    idle(3);
    check("short_idle_novalid", 64'(valid_cnt - v0), 64'd0);
    check("short_idle_noerr",   64'(err_cnt - e0),   64'd1);
    check_fields("stuff");
    idle(11);
    good_frame("after_idle", m);

    // 4: corrupted data bit -> CRC error
    m = '0; m.sid = 11'h3C1; m.dlc = 4'd4; m.data = 64'h1234_5678;
    crc_bad_frame("crc", m);

    // 5: remote frame DLC 8, then data frame DLC 12
    m = '0; m.rtr = 1'b1; m.sid = 11'h2AA; m.dlc = 4'd8; m.data = '1;
    good_frame("rtr", m);
    m = '0; m.sid = 11'h111; m.dlc = 4'd12; m.data = 64'h8877_6655_4433_2211;
    good_frame("dlc12", m);

    // randomized frames
    for (int n = 0; n < 24; n++) begin
      m = rand_msg();
      if (n % 6 == 5 && nbytes_of(m) > 0) crc_bad_frame("rnd_crc", m);
      else good_frame("rnd", m);
    end

    // en=0 drops a frame silently and keeps published fields
    v0 = valid_cnt; e0 = err_cnt;
    m = rand_msg(); m.rtr = 1'b0; m.dlc = 4'd8;
    build_frame(m, -1, 1'b0);
    send_frame(25);
    check("en_busy_before", 64'(bus.o_depacketizer_busy), 64'd1);
    @(negedge clk); bus.i_depacketizer_en = 1'b0;
    repeat (4) @(negedge clk);
    check("en_busy", 64'(bus.o_depacketizer_busy), 64'd0);
    check_fields("en");
    bus.i_depacketizer_en = 1'b1;
    idle(11);
    check("en_novalid", 64'(valid_cnt - v0), 64'd0);
    check("en_noerr",   64'(err_cnt - e0),   64'd0);
    good_frame("en_after", m);

    // 6: reset during DATA
    v0 = valid_cnt; e0 = err_cnt;
    m = '0; m.sid = 11'h0F0; m.dlc = 4'd8; m.data = 64'hA5A5_5A5A_0F0F_F0F0;
    build_frame(m, -1, 1'b0);
    send_frame(35);
    check("mid_busy", 64'(bus.o_depacketizer_busy), 64'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_sid = '0; exp_ide = 1'b0; exp_eid = '0; exp_rtr = 1'b0; exp_dlc = '0; exp_data = '0;
    check("mrst_busy", 64'(bus.o_depacketizer_busy),     64'd0);
    check("mrst_code", 64'(bus.o_depacketizer_err_code), 64'd0);
    check_fields("mrst");
    idle(5);
    send_frame(-1);
    idle(3);
    check("mrst_novalid", 64'(valid_cnt - v0), 64'd0);
    check("mrst_noerr",   64'(err_cnt - e0),   64'd0);
    idle(11);
    good_frame("mrst_after", m);

    check("never_both", 64'(both_cnt), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
